// File: rtl/merge_tfifo_if.sv
//------------------------------------------------------------------------------
// merge_tfifo_if : valid/ready token handshake bundle around merge_tfifo
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface merge_tfifo_if #(
  parameter int BITWIDTH = 32
);
  logic [BITWIDTH-1:0] ins;
  logic                ins_valid;
  logic                ins_ready;
  logic [BITWIDTH-1:0] outs;
  logic                outs_valid;
  logic                outs_ready;

  // master: the environment that feeds tokens in and consumes them
  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  // slave: the FIFO itself
  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );
endinterface

`default_nettype wire

// File: rtl/merge_tfifo.sv
//------------------------------------------------------------------------------
// merge_tfifo : transparent elastic FIFO with zero-latency bypass when empty
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module merge_tfifo #(
  parameter int NUM_SLOTS = 4,
  parameter int BITWIDTH  = 32
) (
  input  logic          clk,
  input  logic          rst,
  merge_tfifo_if.slave  bus
);
  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

  logic [BITWIDTH-1:0] mem [NUM_SLOTS];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;

  logic empty;
  logic full;
  logic enq;
  logic deq;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  assign bus.outs_valid = bus.ins_valid | ~empty;
  assign bus.outs       = empty ? bus.ins : mem[head];
  assign bus.ins_ready  = ~full | bus.outs_ready;

  // A token that bypasses (empty and consumer ready) never touches storage.
  assign enq = bus.ins_valid & bus.ins_ready & ~(empty & bus.outs_ready);
  assign deq = ~empty & bus.outs_ready;

  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      mem[tail] <= bus.ins;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);
      end
      if (deq) begin
        head <= (head == LAST_PTR) ? '0 : head + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

`default_nettype wire
